// File: rtl/pipe_adder.sv
// ============================================================================
//  Module      : pipe_adder
//  Description : Pipelined add/subtract unit. The carry chain is split into
//                STAGES equal segments, one register boundary per segment,
//                with a valid/ready handshake on input and output. Sum,
//                carry-out, signed overflow and zero flags come out together.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage inputs (what the stage is about to capture) and outputs
  // (what its registers currently hold). Element k belongs to stage k.
  wire              w_adv;
  wire [STAGES-1:0] w_v_in;
  wire [STAGES-1:0] w_v_q;
  wire [STAGES-1:0] w_c_in;
  wire [STAGES-1:0] w_c_q;
  wire [STAGES-1:0] w_c_d;
  wire [STAGES-1:0][WIDTH-1:0] w_a_in;
  wire [STAGES-1:0][WIDTH-1:0] w_b_in;
  wire [STAGES-1:0][WIDTH-1:0] w_s_in;
  wire [STAGES-1:0][WIDTH-1:0] w_s_d;
  wire [STAGES-1:0][WIDTH-1:0] w_a_q;
  wire [STAGES-1:0][WIDTH-1:0] w_b_q;
  wire [STAGES-1:0][WIDTH-1:0] w_s_q;

  logic r_ovf;
  logic r_zero;

  // The whole pipeline moves as one: it only stalls when a finished result
  // is sitting at the output and the consumer is not taking it.
  assign w_adv = ~w_v_q[LAST] | out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Bit positions this stage owns inside the full-width sum.
      localparam logic [WIDTH-1:0] SEG_MASK =
        ((WIDTH'(1) << CW) - WIDTH'(1)) << (k * CW);

      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;
      logic             r_v;
      wire  [CW:0]      w_seg;

      if (k == 0) begin : g_first
        // Operand prep at accept: subtraction is A + ~B + 1.
        assign w_v_in[k] = in_valid;
        assign w_a_in[k] = a;
        assign w_b_in[k] = sub ? ~b : b;
        assign w_c_in[k] = sub | cin;
        assign w_s_in[k] = '0;
      end else begin : g_next
        assign w_v_in[k] = w_v_q[k-1];
        assign w_a_in[k] = w_a_q[k-1];
        assign w_b_in[k] = w_b_q[k-1];
        assign w_c_in[k] = w_c_q[k-1];
        assign w_s_in[k] = w_s_q[k-1];
      end

      assign w_seg    = {1'b0, w_a_in[k][k*CW +: CW]}
                      + {1'b0, w_b_in[k][k*CW +: CW]}
                      + {{CW{1'b0}}, w_c_in[k]};
      assign w_s_d[k] = (w_s_in[k] & ~SEG_MASK)
                      | ((WIDTH'(w_seg[CW-1:0]) << (k * CW)) & SEG_MASK);
      assign w_c_d[k] = w_seg[CW];

      // Stage register: valid bit follows the flow, payload only loads for a
      // real operation so bubbles never disturb held data.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
        end else begin
          if (w_adv) begin
            r_v <= w_v_in[k];
          end
          if (w_adv && w_v_in[k]) begin
            r_a <= w_a_in[k];
            r_b <= w_b_in[k];
            r_s <= w_s_d[k];
            r_c <= w_c_d[k];
          end
        end
      end

      assign w_v_q[k] = r_v;
      assign w_a_q[k] = r_a;
      assign w_b_q[k] = r_b;
      assign w_s_q[k] = r_s;
      assign w_c_q[k] = r_c;
    end
  endgenerate

  // Flags are captured alongside the final sum segment so they are aligned
  // with the result and have no combinational path from the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv && w_v_in[LAST]) begin
      r_ovf  <= (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1])
              & (w_s_d[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
      r_zero <= ~|w_s_d[LAST];
    end
  end

  // Consumed operand segments and unfinished sum segments are not needed
  // downstream; they are gathered here so the intent is explicit.
  wire w_unused;
  assign w_unused = ^{w_a_q, w_b_q, w_s_q, w_s_d, w_a_in, w_b_in};

  assign in_ready  = w_adv;
  assign out_valid = w_v_q[LAST];
  assign sum       = w_s_q[LAST];
  assign cout      = w_c_q[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ============================================================================
//  Module      : tb_pipe_adder
//  Description : Self-checking bench for pipe_adder. A queue-based reference
//                model predicts every retired result; directed cases pin
//                literal values, latency, back-pressure and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_adder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b1;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;

  logic          in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0]  sum;
  logic          in_ready1, out_valid1, cout1, ovf1, zero1;
  logic [W-1:0]  sum1;
  logic          in_ready4, out_valid4, cout4, ovf4, zero4;
  logic [W-1:0]  sum4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          log_en = 1'b0;
  bit          hold   = 1'b0;
  logic [34:0] held   = '0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  pipe_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
    .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));

  pipe_adder #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4),
    .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {sum, cout, ovf, zero}.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms);
    longint      sa, sb, r;
    logic [32:0] u;
    logic [31:0] s;
    logic        co;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) begin
      r  = sa - sb;
      s  = ma - mb;
      co = (ma >= mb);
    end else begin
      r  = sa + sb + longint'(mc);
      u  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
      s  = u[31:0];
      co = u[32];
    end
    return {s, co, (r > 64'sd2147483647) || (r < -64'sd2147483648), (s == 32'd0)};
  endfunction

  // Cycle monitor: handshake rule, hold stability, in-order retirement.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({sum, cout, ovf, zero}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stale_result", 64'(sum), 64'hDEAD_0000_0000);
        end else begin
          chk("retire", 64'({sum, cout, ovf, zero}), 64'(exp_q.pop_front()));
        end
        if (log_en) got_q.push_back(sum);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      hold = out_valid && !out_ready;
      held = {sum, cout, ovf, zero};
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
    bit got;
    got = 1'b0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
    end
    #1;
    chk("accept_in_time", 64'(got), 64'd1);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic ts, input logic [34:0] exp, input string nm);
    int lat;
    lat = 0;
    out_ready = 1'b1;
    send(ta, tb, tc, ts);
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk);
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk(nm, 64'({sum, cout, ovf, zero}), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          l1, l2, l4;
    logic [34:0] r1, r2, r4;

    // Model pinned to hand-computed values.
    chk("model_carry", 64'(model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({32'h0, 1'b1, 1'b0, 1'b1}));
    chk("model_sub",   64'(model(32'h5, 32'h7, 1'b0, 1'b1)), 64'({32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}));
    chk("model_ovf",   64'(model(32'h8000_0000, 32'h1, 1'b0, 1'b1)), 64'({32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}));

    // Reset with in_valid held high.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum_flags", 64'({sum, cout, ovf, zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Carry across segments on depths 1, 2 and 4 at once.
    a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    l1 = 0; l2 = 0; l4 = 0; r1 = '0; r2 = '0; r4 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid1 && l1 == 0) begin l1 = c; r1 = {sum1, cout1, ovf1, zero1}; end
      if (out_valid  && l2 == 0) begin l2 = c; r2 = {sum,  cout,  ovf,  zero};  end
      if (out_valid4 && l4 == 0) begin l4 = c; r4 = {sum4, cout4, ovf4, zero4}; end
      @(posedge clk);
    end
    #1;
    chk("carry_s1_latency", 64'(l1), 64'd1);
    chk("carry_s2_latency", 64'(l2), 64'd2);
    chk("carry_s4_latency", 64'(l4), 64'd4);
    chk("carry_s1", 64'(r1), 64'({32'h0, 1'b1, 1'b0, 1'b1}));
    chk("carry_s2", 64'(r2), 64'({32'h0, 1'b1, 1'b0, 1'b1}));
    chk("carry_s4", 64'(r4), 64'({32'h0, 1'b1, 1'b0, 1'b1}));

    // Signed overflow, carry-in and subtraction.
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0}, "ovf_add");
    do_op(32'h0, 32'h0, 1'b1, 1'b0, {32'h1, 1'b0, 1'b0, 1'b0}, "cin_add");
    do_op(32'h5, 32'h7, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, "sub_5_7");
    do_op(32'h7, 32'h5, 1'b1, 1'b1, {32'h2, 1'b1, 1'b0, 1'b0}, "sub_7_5");
    do_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, "sub_ovf");

    // Back-pressure mid-stream.
    got_q.delete(); log_en = 1'b1; out_ready = 1'b1;
    fork
      begin
        send(32'd1, 32'd1, 1'b0, 1'b0);
        send(32'd2, 32'd2, 1'b0, 1'b0);
        send(32'd3, 32'd3, 1'b0, 1'b0);
        send(32'd4, 32'd4, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        @(posedge clk); @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1 log_en = 1'b0;
    chk("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("bp_result", 64'(got_q[i]), 64'(2 * (i + 1)));

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(32'd11, 32'd22, 1'b0, 1'b0);
    send(32'd33, 32'd44, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    do_op(32'd9, 32'd1, 1'b0, 1'b0, {32'hA, 1'b0, 1'b0, 1'b0}, "after_rst");

    // Randomized traffic with random stalls.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = pick();
      b   = pick();
      cin = $urandom_range(0, 1) == 1;
      sub = $urandom_range(0, 1) == 1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
